// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline controller.
//   ctrl_state_t : controller FSM states (RUN, DWAIT, HALTED)
//   latch_cmd_t  : per-latch command (HOLD, CAPTURE, FLUSH)
//   latch_decode : maps a latch command onto its {en, flush} output pair
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2
    } latch_cmd_t;

    // Returns {en, flush}; the two bits are never both set.
    function automatic logic [1:0] latch_decode(latch_cmd_t cmd);
        logic [1:0] ef;
        ef = 2'b00;
        case (cmd)
            CAPTURE: ef = 2'b10;
            FLUSH:   ef = 2'b01;
            default: ef = 2'b00;
        endcase
        return ef;
    endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline. It is the only
// driver of the pipeline latch enables and the PC enable.
//
// Handshake semantics: there is no valid/ready pair here. ihit/dhit are
// level "done this cycle" indications sampled combinationally; every latch
// gets en=1 (capture), flush=1 (load bubble) or both 0 (hold) each cycle.
//
// Ports
//   CLK, RST                 clock (rising edge), async active-high reset
//   ihit, dhit               icache / dcache completion this cycle
//   mem_dren, mem_dwen       EX/MEM holds a load / store
//   mem_pcsrc, mem_halt      MEM-stage redirect / halt
//   idex_dren, idex_rt       load in ID/EX and its destination
//   ifid_rs, ifid_rt         source registers of the IF/ID instruction
//   pc_en                    PC loads its next/redirect value
//   *_en, *_flush            per-latch capture / bubble commands
//   halt_o                   processor halted
//   stall_cycles             saturating count of pc_en=0 cycles (not halted)
//   dbg_state_o              current FSM state, for observation
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int STALLCNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ihit,
    input  logic                  dhit,
    input  logic                  mem_dren,
    input  logic                  mem_dwen,
    input  logic                  mem_pcsrc,
    input  logic                  mem_halt,
    input  logic                  idex_dren,
    input  logic [REG_W-1:0]      idex_rt,
    input  logic [REG_W-1:0]      ifid_rs,
    input  logic [REG_W-1:0]      ifid_rt,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  memwb_flush,
    output logic                  halt_o,
    output logic [STALLCNT_W-1:0] stall_cycles,
    output ctrl_state_t           dbg_state_o
);

    ctrl_state_t           state_q, state_d;
    logic [STALLCNT_W-1:0] stall_q, stall_d;

    latch_cmd_t ifid_cmd, idex_cmd, exmem_cmd, memwb_cmd;
    logic       pc_en_w;
    logic       memacc;
    logic       loaduse;

    assign memacc  = mem_dren | mem_dwen;
    assign loaduse = idex_dren && (idex_rt != '0) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    // Next state and latch commands, highest priority first.
    always_comb begin
        state_d   = state_q;
        pc_en_w   = 1'b0;
        ifid_cmd  = HOLD;
        idex_cmd  = HOLD;
        exmem_cmd = HOLD;
        memwb_cmd = HOLD;

        if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (memacc && !dhit) begin
            // Data miss: freeze the front of the pipe, bubble into WB.
            memwb_cmd = FLUSH;
            state_d   = DWAIT;
        end else begin
            // A completed data access (or a stray DWAIT) advances normally
            // and the remaining hazard rules still apply.
            state_d = RUN;
            if (mem_halt) begin
                ifid_cmd  = FLUSH;
                idex_cmd  = FLUSH;
                exmem_cmd = FLUSH;
                memwb_cmd = CAPTURE;
                state_d   = HALTED;
            end else if (mem_pcsrc) begin
                ifid_cmd  = FLUSH;
                idex_cmd  = FLUSH;
                exmem_cmd = FLUSH;
                memwb_cmd = CAPTURE;
                pc_en_w   = 1'b1;
            end else if (loaduse) begin
                idex_cmd  = FLUSH;
                exmem_cmd = CAPTURE;
                memwb_cmd = CAPTURE;
            end else if (!ihit) begin
                ifid_cmd  = FLUSH;
                idex_cmd  = CAPTURE;
                exmem_cmd = CAPTURE;
                memwb_cmd = CAPTURE;
            end else begin
                ifid_cmd  = CAPTURE;
                idex_cmd  = CAPTURE;
                exmem_cmd = CAPTURE;
                memwb_cmd = CAPTURE;
                pc_en_w   = 1'b1;
            end
        end
    end

    // Stall counter: counts non-halted cycles with the PC frozen, saturating.
    always_comb begin
        stall_d = stall_q;
        if (!pc_en_w && (state_q != HALTED) && (stall_q != {STALLCNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    // While reset is asserted every latch is forced to bubble and the PC holds.
    always_comb begin
        if (RST) begin
            pc_en = 1'b0;
            {ifid_en,  ifid_flush}  = 2'b01;
            {idex_en,  idex_flush}  = 2'b01;
            {exmem_en, exmem_flush} = 2'b01;
            {memwb_en, memwb_flush} = 2'b01;
        end else begin
            pc_en = pc_en_w;
            {ifid_en,  ifid_flush}  = latch_decode(ifid_cmd);
            {idex_en,  idex_flush}  = latch_decode(idex_cmd);
            {exmem_en, exmem_flush} = latch_decode(exmem_cmd);
            {memwb_en, memwb_flush} = latch_decode(memwb_cmd);
        end
    end

    assign halt_o       = (state_q == HALTED);
    assign stall_cycles = stall_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic ihit, dhit, mem_dren, mem_dwen, mem_pcsrc, mem_halt, idex_dren;
  logic [RW-1:0] idex_rt, ifid_rs, ifid_rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_o;
  logic [CW-1:0] stall_cycles;
  ctrl_state_t dbg_state;

  pipeline_ctrl #(.REG_W(RW), .STALLCNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_pcsrc(mem_pcsrc),
    .mem_halt(mem_halt), .idex_dren(idex_dren), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .pc_en(pc_en),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halt_o(halt_o),
    .stall_cycles(stall_cycles), .dbg_state_o(dbg_state)
  );

  // {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush}
  logic [8:0] dut_vec;
  assign dut_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush};

  localparam logic [8:0] V_RESET  = 9'b0_0000_1111;
  localparam logic [8:0] V_FROZEN = 9'b0_0000_0000;
  localparam logic [8:0] V_MISS   = 9'b0_0000_0001;
  localparam logic [8:0] V_HALT   = 9'b0_0001_1110;
  localparam logic [8:0] V_REDIR  = 9'b1_0001_1110;
  localparam logic [8:0] V_LDUSE  = 9'b0_0011_0100;
  localparam logic [8:0] V_IMISS  = 9'b0_0111_1000;
  localparam logic [8:0] V_RUN    = 9'b1_1111_0000;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state: halted flag, "last cycle was a data miss" flag, integer count.
  bit m_halted = 0;
  bit m_dwait = 0;
  int m_cnt = 0;

  // Classify the cycle by the first rule that applies.
  typedef enum int {S_FROZEN, S_MISS, S_HALT, S_REDIR, S_LDUSE, S_IMISS, S_RUN} scen_t;

  function automatic scen_t scenario();
    bit acc, lu;
    acc = mem_dren || mem_dwen;
    lu = idex_dren && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    if (m_halted) return S_FROZEN;
    if (acc && !dhit) return S_MISS;
    if (mem_halt) return S_HALT;
    if (mem_pcsrc) return S_REDIR;
    if (lu) return S_LDUSE;
    if (!ihit) return S_IMISS;
    return S_RUN;
  endfunction

  function automatic logic [8:0] scen_vec(scen_t s);
    case (s)
      S_FROZEN: return V_FROZEN;
      S_MISS:   return V_MISS;
      S_HALT:   return V_HALT;
      S_REDIR:  return V_REDIR;
      S_LDUSE:  return V_LDUSE;
      S_IMISS:  return V_IMISS;
      default:  return V_RUN;
    endcase
  endfunction

  always @(posedge CLK or posedge RST) begin
    scen_t s;
    if (RST) begin
      m_halted = 0;
      m_dwait = 0;
      m_cnt = 0;
    end else begin
      s = scenario();
      if (!m_halted && scen_vec(s)[8] == 1'b0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (!m_halted) begin
        m_dwait = (s == S_MISS);
        m_halted = (s == S_HALT);
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Expected output vectors queued by the model, drained each negedge.
  logic [8:0] exp_q[$];

  always @(negedge CLK) begin
    logic [8:0] ev;
    ctrl_state_t es;
    exp_q.push_back(RST ? V_RESET : scen_vec(scenario()));
    ev = exp_q.pop_front();
    es = m_halted ? HALTED : (m_dwait ? DWAIT : RUN);
    check("model_vec", {23'd0, dut_vec}, {23'd0, ev});
    check("model_halt", {31'd0, halt_o}, {31'd0, m_halted});
    check("model_cnt", {28'd0, stall_cycles}, m_cnt);
    check("model_state", {30'd0, dbg_state}, {30'd0, es});
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ihit = 1; dhit = 0; mem_dren = 0; mem_dwen = 0; mem_pcsrc = 0;
    mem_halt = 0; idex_dren = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_sample();
    @(negedge CLK);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle_inputs();
    RST = 1;
    at_sample();
    check("reset_vec", {23'd0, dut_vec}, {23'd0, V_RESET});
    check("reset_halt", {31'd0, halt_o}, 0);
    check("reset_cnt", {28'd0, stall_cycles}, 0);
    next_cycle();
    RST = 0;
    at_sample();
    check("run_after_reset", {23'd0, dut_vec}, {23'd0, V_RUN});
    next_cycle();

    // Load miss for 3 cycles, then hit.
    mem_dren = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      at_sample();
      check("miss_vec", {23'd0, dut_vec}, {23'd0, V_MISS});
      next_cycle();
      check("miss_state", {30'd0, dbg_state}, {30'd0, DWAIT});
    end
    dhit = 1;
    at_sample();
    check("dhit_vec", {23'd0, dut_vec}, {23'd0, V_RUN});
    check("miss_cnt", {28'd0, stall_cycles}, 3);
    next_cycle();
    check("dhit_state", {30'd0, dbg_state}, {30'd0, RUN});
    mem_dren = 0; dhit = 0;

    // Load-use on rs, then rt=0 which is never a hazard.
    idex_dren = 1; idex_rt = 5; ifid_rs = 5; ifid_rt = 3;
    at_sample();
    check("loaduse_vec", {23'd0, dut_vec}, {23'd0, V_LDUSE});
    next_cycle();
    idex_rt = 0; ifid_rs = 0;
    at_sample();
    check("r0_no_stall", {23'd0, dut_vec}, {23'd0, V_RUN});
    next_cycle();

    // Redirect overrides load-use and icache miss.
    idex_rt = 7; ifid_rt = 7; ihit = 0; mem_pcsrc = 1;
    at_sample();
    check("redirect_vec", {23'd0, dut_vec}, {23'd0, V_REDIR});
    next_cycle();
    idle_inputs();
    ihit = 0;
    at_sample();
    check("imiss_vec", {23'd0, dut_vec}, {23'd0, V_IMISS});
    next_cycle();
    ihit = 1;

    // Halt, then frozen for 10 cycles with the counter unchanged.
    mem_halt = 1;
    at_sample();
    check("halt_vec", {23'd0, dut_vec}, {23'd0, V_HALT});
    check("halt_not_yet", {31'd0, halt_o}, 0);
    next_cycle();
    mem_halt = 0; ihit = 0;
    for (int i = 0; i < 10; i++) begin
      at_sample();
      check("halted_vec", {23'd0, dut_vec}, {23'd0, V_FROZEN});
      check("halted_flag", {31'd0, halt_o}, 1);
      next_cycle();
    end
    check("halted_cnt", {28'd0, stall_cycles}, 6);

    // Reset out of HALTED, then reset in the middle of a data miss.
    RST = 1;
    at_sample();
    check("rst_from_halt", {31'd0, halt_o}, 0);
    next_cycle();
    RST = 0; ihit = 1; mem_dwen = 1; dhit = 0;
    next_cycle();
    next_cycle();
    check("pre_rst_cnt", {28'd0, stall_cycles}, 2);
    RST = 1;
    #1;
    check("rst_dwait_state", {30'd0, dbg_state}, {30'd0, RUN});
    check("rst_dwait_cnt", {28'd0, stall_cycles}, 0);
    next_cycle();
    RST = 0;
    idle_inputs();

    // Saturation: 20 icache misses on a 4-bit counter.
    ihit = 0;
    for (int i = 0; i < 20; i++) next_cycle();
    at_sample();
    check("sat_cnt", {28'd0, stall_cycles}, 15);
    next_cycle();

    // Store hit with a random instruction-side mix, checked by the model.
    for (int i = 0; i < 40; i++) begin
      ihit = 1'($urandom_range(0, 1));
      mem_dwen = 1'($urandom_range(0, 1));
      dhit = 1'($urandom_range(0, 1));
      idex_dren = 1'($urandom_range(0, 1));
      idex_rt = 5'($urandom_range(0, 3));
      ifid_rs = 5'($urandom_range(0, 3));
      mem_pcsrc = !mem_dwen && ($urandom_range(0, 3) == 0);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
